e_mdu: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit for the E stage of the pipelined MIPS core.
//  - Extends the single-cycle E-stage ALU with signed/unsigned mult/div, HI/LO registers and mthi/mtlo.
//  - Exposes Busy so the hazard unit stalls D-stage mult/div/mf/mt instructions while an operation runs.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/e_mdu_popcnt.sv | 18 +
 rtl/e_mdu.sv | 151 +++++++++++++++
 tb/tb_e_mdu.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
// Op encodings, FSM state constants and the counter-width helper.
package mdu_pkg;

  // MDU op encodings carried on MDU_Op
  localparam logic [3:0] MDU_MULT   = 4'd0;
  localparam logic [3:0] MDU_MULTU  = 4'd1;
  localparam logic [3:0] MDU_DIV    = 4'd2;
  localparam logic [3:0] MDU_DIVU   = 4'd3;
  localparam logic [3:0] MDU_MTHI   = 4'd4;
  localparam logic [3:0] MDU_MTLO   = 4'd5;
  localparam logic [3:0] MDU_MFHI   = 4'd6;
  localparam logic [3:0] MDU_MFLO   = 4'd7;
  localparam logic [3:0] MDU_POPCNT = 4'd8;

  // FSM states
  localparam logic [0:0] MDU_IDLE = 1'b0;
  localparam logic [0:0] MDU_RUN  = 1'b1;

  // Bits needed to hold max(a, b) as an unsigned count
  function automatic int cnt_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = 1;
    while ((1 << w) <= m) w++;
    return w;
  endfunction

endpackage

// File: rtl/e_mdu_popcnt.sv
// Combinational population count of a WIDTH-bit word, zero-extended to WIDTH.
// Only instantiated when E_MDU_POPCNT_EN is defined.
module e_mdu_popcnt #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] bits,
  output logic [WIDTH-1:0] count
);

  // Sum of the set bits
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + WIDTH'(bits[i]);
    end
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multi-cycle multiply/divide unit with HI/LO registers.
// Results are computed on the accept edge and held in pending registers;
// HI/LO only change on the edge where Busy falls, so the old values stay
// readable by mfhi/mflo for the whole operation.
// Optional feature macro: E_MDU_POPCNT_EN (adds MDU_POPCNT -> LO).
// Handshake: an op is accepted when Start is high at a rising edge while the
// unit is idle; Start while Busy is ignored. Busy is a pure flop output.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [3:0]       MDU_Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic [WIDTH-1:0] HI_Out,
  output logic [WIDTH-1:0] LO_Out,
  output logic [0:0]       dbg_state
);

  localparam int CW = cnt_width(MUL_CYCLES, DIV_CYCLES);
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo, pend_hi, pend_lo;

  // Products: operands extended to 2*WIDTH so one unsigned multiply serves both
  logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
  assign a_sx   = {{WIDTH{SrcA[WIDTH-1]}}, SrcA};
  assign b_sx   = {{WIDTH{SrcB[WIDTH-1]}}, SrcB};
  assign a_zx   = {{WIDTH{1'b0}}, SrcA};
  assign b_zx   = {{WIDTH{1'b0}}, SrcB};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // Division: divisors are forced to 1 in the special cases so the raw
  // divider never sees /0 or the overflowing most-negative / -1
  logic             div_zero, div_ovf;
  logic [WIDTH-1:0] den_s, den_u, q_s, r_s, q_u, r_u;
  logic [WIDTH-1:0] div_hi, div_lo, divu_hi, divu_lo;
  assign div_zero = (SrcB == '0);
  assign div_ovf  = (SrcA == MOST_NEG) && (SrcB == '1);
  assign den_s    = (div_zero || div_ovf) ? ONE_W : SrcB;
  assign den_u    = div_zero ? ONE_W : SrcB;
  assign q_s      = $unsigned($signed(SrcA) / $signed(den_s));
  assign r_s      = $unsigned($signed(SrcA) % $signed(den_s));
  assign q_u      = SrcA / den_u;
  assign r_u      = SrcA % den_u;

  // Select signed/unsigned divide results including the special cases
  always_comb begin
    div_hi  = r_s;
    div_lo  = q_s;
    divu_hi = r_u;
    divu_lo = q_u;
    if (div_zero) begin
      div_hi  = SrcA;
      div_lo  = '1;
      divu_hi = SrcA;
      divu_lo = '1;
    end else if (div_ovf) begin
      div_hi = '0;
      div_lo = MOST_NEG;
    end
  end

`ifdef E_MDU_POPCNT_EN
  logic [WIDTH-1:0] pop;
  e_mdu_popcnt #(.WIDTH(WIDTH)) u_popcnt (
    .bits  (SrcB),
    .count (pop)
  );
`endif

  // FSM, counter, pending results and HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= MDU_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (Start) begin
            case (MDU_Op)
              MDU_MULT: begin
                {pend_hi, pend_lo} <= prod_s;
                cnt   <= MUL_CNT;
                state <= MDU_RUN;
              end
              MDU_MULTU: begin
                {pend_hi, pend_lo} <= prod_u;
                cnt   <= MUL_CNT;
                state <= MDU_RUN;
              end
              MDU_DIV: begin
                pend_hi <= div_hi;
                pend_lo <= div_lo;
                cnt     <= DIV_CNT;
                state   <= MDU_RUN;
              end
              MDU_DIVU: begin
                pend_hi <= divu_hi;
                pend_lo <= divu_lo;
                cnt     <= DIV_CNT;
                state   <= MDU_RUN;
              end
              MDU_MTHI: hi <= SrcA;
              MDU_MTLO: lo <= SrcA;
`ifdef E_MDU_POPCNT_EN
              MDU_POPCNT: lo <= pop;
`endif
              default: ;
            endcase
          end
        end
        MDU_RUN: begin
          if (cnt == CNT_ONE) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            cnt   <= '0;
            state <= MDU_IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

  assign Busy      = (state == MDU_RUN);
  assign HI_Out    = hi;
  assign LO_Out    = lo;
  assign dbg_state = state;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: expected {HI,LO} pushed at issue time,
// popped and compared when the unit reports completion.
module tb_e_mdu;
  import mdu_pkg::*;

  localparam int W   = 32;
  localparam int MUL = 5;
  localparam int DIV = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         Start;
  logic [3:0]   MDU_Op;
  logic [W-1:0] SrcA, SrcB;
  logic         Busy;
  logic [W-1:0] HI_Out, LO_Out;
  logic [0:0]   dbg_state;

  logic [2*W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  logic [W-1:0] m_hi, m_lo;

  e_mdu #(.WIDTH(W), .MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .MDU_Op    (MDU_Op),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Busy      (Busy),
    .HI_Out    (HI_Out),
    .LO_Out    (LO_Out),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: next {HI,LO} for an op given the current model state
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    int     ia, ib, q, r;
    logic [63:0] res;
    res = {m_hi, m_lo};
    case (op)
      MDU_MULT: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = 64'(sa * sb);
      end
      MDU_MULTU: res = {32'd0, a} * {32'd0, b};
      MDU_DIV: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
        else begin
          ia = $signed(a);
          ib = $signed(b);
          q  = ia / ib;
          r  = ia % ib;
          res = {r, q};
        end
      end
      MDU_DIVU: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      MDU_MTHI: res = {a, m_lo};
      MDU_MTLO: res = {m_hi, a};
`ifdef E_MDU_POPCNT_EN
      MDU_POPCNT: res = {m_hi, 32'($countones(b))};
`endif
      default: res = {m_hi, m_lo};
    endcase
    return res;
  endfunction

  function automatic int op_cycles(input logic [3:0] op);
    if (op == MDU_MULT || op == MDU_MULTU) return MUL;
    if (op == MDU_DIV || op == MDU_DIVU) return DIV;
    return 0;
  endfunction

  // Issue one op, optionally poke an MTHI while busy, wait for completion, compare
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit poke);
    int n;
    int cyc;
    logic [63:0] exp;
    cyc = op_cycles(op);
    exp_q.push_back(model(op, a, b));
    @(negedge clk);
    Start = 1'b1; MDU_Op = op; SrcA = a; SrcB = b;
    @(negedge clk);
    Start = 1'b0;
    n = 0;
    while (Busy && n < 200) begin
      check_val({tag, "_hold"}, {HI_Out, LO_Out}, {m_hi, m_lo});
      if (n == 0) check_val({tag, "_state_run"}, 64'(dbg_state), 64'(MDU_RUN));
      if (poke && n == 0) begin
        Start = 1'b1; MDU_Op = MDU_MTHI; SrcA = 32'h0000_1234;
      end else begin
        Start = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    Start = 1'b0;
    check_val({tag, "_busy_cycles"}, 64'(n), 64'(cyc));
    check_val({tag, "_state_idle"}, 64'(dbg_state), 64'(MDU_IDLE));
    exp = exp_q.pop_front();
    {m_hi, m_lo} = exp;
    check_val(tag, {HI_Out, LO_Out}, exp);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b1; Start = 1'b0; MDU_Op = 4'd0; SrcA = '0; SrcB = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_val("reset_busy", 64'(Busy), 64'd0);
    check_val("reset_hilo", {HI_Out, LO_Out}, 64'd0);

    run_op("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("divu_zero", MDU_DIVU, 32'd7, 32'd0, 1'b0);
    run_op("div_zero", MDU_DIV, 32'hFFFF_FFF0, 32'd0, 1'b0);
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("mthi_busy", MDU_MULT, 32'd11, 32'd13, 1'b1);
    run_op("mthi_idle", MDU_MTHI, 32'h0000_1234, 32'd0, 1'b0);
    run_op("mtlo_idle", MDU_MTLO, 32'hCAFE_0001, 32'd0, 1'b0);
    run_op("mfhi", MDU_MFHI, 32'h5555_5555, 32'd9, 1'b0);
    run_op("unknown_op", 4'hF, 32'hAAAA_AAAA, 32'h1111_1111, 1'b0);
    run_op("popcnt", MDU_POPCNT, 32'h0000_0000, 32'hF0F0_000F, 1'b0);

    // reset during the third cycle of a divide
    @(negedge clk);
    Start = 1'b1; MDU_Op = MDU_DIV; SrcA = 32'd100; SrcB = 32'd7;
    @(negedge clk);
    Start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("abort_busy", 64'(Busy), 64'd0);
    check_val("abort_hilo", {HI_Out, LO_Out}, 64'd0);
    m_hi = '0; m_lo = '0;
    run_op("mult_after_abort", MDU_MULT, 32'd2, 32'd3, 1'b0);

    // random mult/div traffic
    for (int i = 0; i < 8; i++) begin
      rop = 4'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
      run_op("random", rop, ra, rb, 1'b0);
    end

    check_val("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
